// File: rtl/cmp_share_ctrl.sv
// cmp_share_ctrl: round-robin sharing of one WIDTH-bit inequality comparator.
// Optional saturating diff counter enabled by CMP_SHARE_STATS_EN.
module cmp_share_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
`ifdef CMP_SHARE_STATS_EN
  input  logic             cnt_clr,
  output logic [7:0]       diff_cnt,
`endif
  output logic             ack0,
  output logic             ack1,
  output logic             diff,
  output logic [WIDTH-1:0] diff_vec,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_diff;
  logic [WIDTH-1:0] r_diff_vec;
  logic             w_gnt_vld;
  logic             w_gnt1;
  logic [WIDTH-1:0] w_diff_vec;

  assign w_diff_vec = r_op_a ^ r_op_b;

  // w_gnt1 selects requester 1; the pointer only breaks ties
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt1    = 1'b0;
    unique case (1'b1)
      (req0 && !req1): begin
        w_gnt_vld = 1'b1;
        w_gnt1    = 1'b0;
      end
      (!req0 && req1): begin
        w_gnt_vld = 1'b1;
        w_gnt1    = 1'b1;
      end
      (req0 && req1): begin
        w_gnt_vld = 1'b1;
        w_gnt1    = r_ptr;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt1    = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_next = S_CMP;
      S_CMP:   w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_owner <= w_gnt1;
        r_ptr   <= ~w_gnt1;
        r_op_a  <= w_gnt1 ? a1 : a0;
        r_op_b  <= w_gnt1 ? b1 : b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_diff     <= 1'b0;
      r_diff_vec <= '0;
    end else if (r_state == S_CMP) begin
      r_diff_vec <= w_diff_vec;
      r_diff     <= |w_diff_vec;
      r_ack0     <= ~r_owner;
      r_ack1     <= r_owner;
    end else if (r_state == S_RESP) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
    end
  end

`ifdef CMP_SHARE_STATS_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (cnt_clr) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_CMP && (|w_diff_vec) && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign diff_cnt = r_cnt;
`endif

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign diff     = r_diff;
  assign diff_vec = r_diff_vec;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// tb_cmp_share_ctrl: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_cmp_share_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, diff, busy;
  logic [W-1:0] diff_vec;
`ifdef CMP_SHARE_STATS_EN
  logic         cnt_clr;
  logic [7:0]   diff_cnt;
`endif

  always #5 clk = ~clk;

  cmp_share_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
`ifdef CMP_SHARE_STATS_EN
    .cnt_clr (cnt_clr),
    .diff_cnt(diff_cnt),
`endif
    .ack0    (ack0),
    .ack1    (ack1),
    .diff    (diff),
    .diff_vec(diff_vec),
    .busy    (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a job is granted, then completes two edges later.
  int           m_left;
  bit           m_ptr, m_own;
  logic [W-1:0] m_a, m_b;
  bit           e_ack0, e_ack1, e_diff;
  logic [W-1:0] e_vec;
  int           e_cnt;

  task automatic m_reset();
    m_left = 0; m_ptr = 0; m_own = 0; m_a = '0; m_b = '0;
    e_ack0 = 0; e_ack1 = 0; e_diff = 0; e_vec = '0; e_cnt = 0;
  endtask

  task automatic m_step();
    bit win1;
    bit inc;
    inc = 0;
    if (m_left == 0) begin
      e_ack0 = 0; e_ack1 = 0;
      if (req0 || req1) begin
        win1  = (req0 && req1) ? m_ptr : req1;
        m_own = win1;
        m_ptr = !win1;
        m_a   = win1 ? a1 : a0;
        m_b   = win1 ? b1 : b0;
        m_left = 2;
      end
    end else if (m_left == 2) begin
      e_vec  = m_a ^ m_b;
      e_diff = (m_a != m_b);
      e_ack0 = !m_own;
      e_ack1 = m_own;
      inc    = e_diff;
      m_left = 1;
    end else begin
      e_ack0 = 0; e_ack1 = 0;
      m_left = 0;
    end
`ifdef CMP_SHARE_STATS_EN
    if (cnt_clr) e_cnt = 0;
    else if (inc && e_cnt < 255) e_cnt++;
`endif
  endtask

  task automatic m_check();
    chk("rnd_ack0", ack0, e_ack0);
    chk("rnd_ack1", ack1, e_ack1);
    chk("rnd_diff", diff, e_diff);
    chk("rnd_vec", diff_vec, e_vec);
    chk("rnd_busy", busy, m_left != 0);
`ifdef CMP_SHARE_STATS_EN
    chk("rnd_cnt", diff_cnt, e_cnt);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         r0;
    logic [W-1:0] ia0, ib0;
    logic         r1;
    logic [W-1:0] ia1, ib1;
    logic         x_ack0, x_ack1, x_diff;
    logic [W-1:0] x_vec;
    logic         x_busy;
  } vec_t;

  vec_t tv[8];

`ifdef CMP_SHARE_STATS_EN
  task automatic txn(input bit who, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit clr);
    if (who) begin req1 = 1; a1 = a; b1 = b; end
    else begin req0 = 1; a0 = a; b0 = b; end
    tick();
    cnt_clr = clr;
    tick();
    cnt_clr = 0; req0 = 0; req1 = 0;
    tick();
  endtask
`endif

  initial begin
    tv[0] = '{1, 5'b10101, 5'b10101, 0, 5'd0, 5'd0, 0, 0, 0, 5'b00000, 1};
    tv[1] = '{1, 5'b10101, 5'b10101, 0, 5'd0, 5'd0, 1, 0, 0, 5'b00000, 1};
    tv[2] = '{0, 5'b10101, 5'b10101, 0, 5'd0, 5'd0, 0, 0, 0, 5'b00000, 0};
    tv[3] = '{0, 5'd0, 5'd0, 1, 5'b10011, 5'b10010, 0, 0, 0, 5'b00000, 1};
    tv[4] = '{0, 5'd0, 5'd0, 1, 5'b10011, 5'b10010, 0, 1, 1, 5'b00001, 1};
    tv[5] = '{0, 5'd0, 5'd0, 0, 5'b10011, 5'b10010, 0, 0, 1, 5'b00001, 0};
    tv[6] = '{0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1, 5'b00001, 0};
    tv[7] = '{0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1, 5'b00001, 0};

`ifdef CMP_SHARE_STATS_EN
    cnt_clr = 0;
`endif
    // reset with random activity on the inputs
    rst_n = 0;
    req0 = 1'($urandom); req1 = 1'($urandom);
    a0 = W'($urandom); b0 = W'($urandom);
    a1 = W'($urandom); b1 = W'($urandom);
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_diff", diff, 0);
    chk("rst_vec", diff_vec, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    chk("rst_busy_clk", busy, 0);
    req0 = 0; req1 = 0;
    #2 rst_n = 1;

    foreach (tv[i]) begin
      req0 = tv[i].r0; a0 = tv[i].ia0; b0 = tv[i].ib0;
      req1 = tv[i].r1; a1 = tv[i].ia1; b1 = tv[i].ib1;
      tick();
      chk($sformatf("tv%0d_ack0", i), ack0, tv[i].x_ack0);
      chk($sformatf("tv%0d_ack1", i), ack1, tv[i].x_ack1);
      chk($sformatf("tv%0d_diff", i), diff, tv[i].x_diff);
      chk($sformatf("tv%0d_vec", i), diff_vec, tv[i].x_vec);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].x_busy);
    end

    // contention: both held from reset, grants alternate 0,1,0,1
    req0 = 1; a0 = 5'b11111; b0 = 5'b11111;
    req1 = 1; a1 = 5'b00000; b1 = 5'b11111;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("cont%0d_ack0", c), ack0, (c % 6) == 2);
      chk($sformatf("cont%0d_ack1", c), ack1, (c % 6) == 5);
      chk($sformatf("cont%0d_busy", c), busy, (c % 3) != 0);
      if ((c % 6) == 2) chk($sformatf("cont%0d_diff0", c), diff, 0);
      if ((c % 6) == 5) chk($sformatf("cont%0d_diff1", c), diff, 1);
    end

    // abort during CMP, then a dual request must go to requester 0
    req0 = 0; req1 = 0;
    do_reset();
    req0 = 1; a0 = 5'b00011; b0 = 5'b00000;
    tick();
    chk("abort_busy_cmp", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack0", ack0, 0);
    chk("abort_vec", diff_vec, 0);
    tick();
    chk("abort_ack0_held", ack0, 0);
    chk("abort_diff_held", diff, 0);
    req1 = 1; a1 = 5'b00001; b1 = 5'b00001;
    #2 rst_n = 1;
    tick();
    chk("abort_regrant_busy", busy, 1);
    tick();
    chk("abort_regrant_ack0", ack0, 1);
    chk("abort_regrant_ack1", ack1, 0);
    chk("abort_regrant_vec", diff_vec, 5'b00011);

    // randomized run against the reference model
    req0 = 0; req1 = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!req0) begin
        if ($urandom_range(3) == 0) begin
          req0 = 1; a0 = W'($urandom);
          b0 = ($urandom_range(2) == 0) ? a0 : W'($urandom);
        end
      end else if ($urandom_range(7) == 0) req0 = 0;
      if (!req1) begin
        if ($urandom_range(3) == 0) begin
          req1 = 1; a1 = W'($urandom);
          b1 = ($urandom_range(2) == 0) ? a1 : W'($urandom);
        end
      end else if ($urandom_range(7) == 0) req1 = 0;
`ifdef CMP_SHARE_STATS_EN
      cnt_clr = ($urandom_range(63) == 0);
`endif
      @(posedge clk);
      m_step();
      #1;
      m_check();
    end

`ifdef CMP_SHARE_STATS_EN
    req0 = 0; req1 = 0; cnt_clr = 0;
    do_reset();
    chk("st_cnt_rst", diff_cnt, 0);
    txn(0, 5'b00001, 5'b00000, 0);
    txn(1, 5'b10101, 5'b10101, 0);
    txn(1, 5'b11111, 5'b00000, 0);
    txn(0, 5'b01010, 5'b01010, 0);
    txn(1, 5'b00100, 5'b00000, 0);
    chk("st_cnt3", diff_cnt, 3);
    for (int k = 0; k < 300; k++) txn(k[0], 5'b10000, 5'b00001, 0);
    chk("st_cnt_sat", diff_cnt, 255);
    txn(0, 5'b11000, 5'b00000, 1);
    chk("st_cnt_clr", diff_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
